iter_muldiv: RTL and testbench
==============================

ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 4 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a, b and op are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-006 The block SHALL have port op, input, 1 bit: 0 = unsigned multiply, 1 = unsigned divide.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands (multiplicand/dividend, multiplier/divisor).
REQ-008 The block SHALL have port out_valid, output, 1 bit: result and err are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port result, output, 2*WIDTH bits: full product for multiply; {remainder, quotient} for divide.
REQ-011 The block SHALL have port err, output, 1 bit: divide-by-zero or unsupported operation.

Function
REQ-012 The block SHALL implement exactly three states: IDLE, RUN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 An operation SHALL be accepted in cycle T when in_valid=1 and in_ready=1; a, b and op SHALL be captured into internal registers, and later input changes SHALL have no effect.
REQ-015 On acceptance the block SHALL enter RUN, perform exactly WIDTH iterations in cycles T+1..T+WIDTH, and enter DONE so that out_valid=1 from cycle T+WIDTH+1.
REQ-016 Multiply SHALL use shift-add, one multiplier bit per iteration, LSB first; result SHALL equal a*b exactly (2*WIDTH bits, no truncation).
REQ-017 Divide SHALL use restoring division, one quotient bit per iteration, MSB first; result[WIDTH-1:0] SHALL be floor(a/b) and result[2*WIDTH-1:WIDTH] SHALL be a mod b.
REQ-018 For divide with b=0, the block SHALL skip RUN and enter DONE at T+1 with result={a, all-ones}, err=1.
REQ-019 err SHALL be 0 for every multiply and for every divide with b!=0.
REQ-020 result and err SHALL be held stable throughout DONE.
REQ-021 DONE SHALL exit to IDLE in the cycle after out_valid=1 and out_ready=1; the next input SHALL NOT be accepted in the same cycle as that transfer (in_ready is 0 in DONE).
REQ-022 While out_ready=0, DONE SHALL be held indefinitely (backpressure).
REQ-023 in_valid asserted during RUN or DONE SHALL be ignored, and no operation SHALL be queued.

Reset
REQ-024 While rst_n=0, regardless of clk, the block SHALL set state=IDLE, in_ready=1, out_valid=0, result=0, err=0, and clear the iteration counter and datapath registers.
REQ-025 An operation in progress when reset asserts SHALL be abandoned, and no out_valid SHALL follow it after reset release.
REQ-026 The first acceptance SHALL be possible on the first rising clk edge with rst_n=1.

Configuration
REQ-027 With macro MULDIV_DIV_EN defined, the divide datapath SHALL be compiled in and SHALL behave per REQ-017/REQ-018.
REQ-028 Without MULDIV_DIV_EN, the divide datapath SHALL be absent; an op=1 operation SHALL be accepted, skip RUN, and enter DONE at T+1 with result=0, err=1.
REQ-029 Multiply behaviour SHALL be identical with and without MULDIV_DIV_EN.

Verification
REQ-030 With WIDTH=8, multiply a=13, b=11 accepted at T, the bench SHALL see out_valid rise at T+9 with result=0x008F, err=0.
REQ-031 With WIDTH=8, multiply a=0xFF, b=0xFF, the bench SHALL see result=0xFE01; with a=0x00, b=0xFF, result=0x0000, latency still 9 cycles.
REQ-032 With WIDTH=8 and MULDIV_DIV_EN defined, divide a=200, b=7, the bench SHALL see result=0x041C (r=4, q=28) at T+9, err=0; with a=5, b=9, result=0x0500.
REQ-033 With WIDTH=8, divide a=0x55, b=0 SHALL give out_valid at T+1 with result=0x55FF, err=1; without the macro, it SHALL give result=0x0000, err=1.
REQ-034 With out_ready held 0 for 5 cycles in DONE, the bench SHALL see result and out_valid stable, in_ready=0, and extra in_valid pulses ignored; after out_ready=1, in_ready=1 in the following cycle.
REQ-035 With rst_n pulsed low at T+4 of a multiply, outputs SHALL go to reset values immediately, no out_valid SHALL appear, and a new multiply 3*4 SHALL return 0x000C.

Source files
------------

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative unsigned multiplier / divider with a valid/ready
// handshake on both sides. One operand bit is processed per clock, so a
// non-trivial operation occupies the block for exactly WIDTH cycles.
//
// Build option:
//   MULDIV_DIV_EN - when defined, the restoring divider is compiled in.
//                   When undefined, op=1 is accepted but reported as an
//                   unsupported operation (result=0, err=1) without running.
//
// Datapath registers are shared between the two operations:
//   multiply : hi_q = running partial product (upper half),
//              lo_q = multiplier shifting out LSB-first while product bits
//                     shift in from the top, opnd_q = multiplicand.
//   divide   : hi_q = partial remainder,
//              lo_q = dividend shifting out MSB-first while quotient bits
//                     shift in from the bottom, opnd_q = divisor.
// After the last iteration {hi_q, lo_q} is directly the architected result.
module iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               err_q, err_d;
`ifdef MULDIV_DIV_EN
  logic               op_q, op_d;
`endif

  logic               accept;
  logic               last_iter;
  logic               skip_run;

  // One shift-add step: add the multiplicand when the current multiplier
  // LSB is set, then shift the whole {carry, hi, lo} right by one.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] mcand
  );
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    addend = lo[0] ? mcand : {WIDTH{1'b0}};
    sum    = {1'b0, hi} + {1'b0, addend};
    return {sum, lo[WIDTH-1:1]};
  endfunction

`ifdef MULDIV_DIV_EN
  // One restoring-division step: bring the next dividend bit into the
  // partial remainder, trial-subtract the divisor, keep the difference only
  // when it is non-negative, and shift the resulting quotient bit in.
  // The shifted remainder needs WIDTH+1 bits because it can reach
  // 2*divisor-1; the subtraction carries one more bit to expose the sign.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] dvsr
  );
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    shifted = {hi, lo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvsr};
    if (!diff[WIDTH+1]) begin
      return {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
    end else begin
      return {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    end
  endfunction
`endif

  assign accept    = in_valid && (state_q == IDLE);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULDIV_DIV_EN
  // Divide by zero has a fixed answer, so it never needs the iteration loop.
  assign skip_run = op && (b == {WIDTH{1'b0}});
`else
  // Without the divider every op=1 request is answered immediately as an error.
  assign skip_run = op;
`endif

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      err_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      err_q   <= err_d;
`ifdef MULDIV_DIV_EN
      op_q    <= op_d;
`endif
    end
  end

  // Next-state logic: IDLE -> RUN (or straight to DONE) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = skip_run ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture operands on acceptance, iterate once per RUN cycle,
  // and otherwise hold (which keeps result/err stable through DONE).
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    err_d  = err_q;
`ifdef MULDIV_DIV_EN
    op_d   = op_q;
`endif
    if (accept) begin
      cnt_d = '0;
`ifdef MULDIV_DIV_EN
      op_d = op;
      if (!op) begin
        hi_d   = '0;
        lo_d   = b;
        opnd_d = a;
        err_d  = 1'b0;
      end else if (b == {WIDTH{1'b0}}) begin
        hi_d   = a;
        lo_d   = '1;
        opnd_d = b;
        err_d  = 1'b1;
      end else begin
        hi_d   = '0;
        lo_d   = a;
        opnd_d = b;
        err_d  = 1'b0;
      end
`else
      if (!op) begin
        hi_d   = '0;
        lo_d   = b;
        opnd_d = a;
        err_d  = 1'b0;
      end else begin
        hi_d   = '0;
        lo_d   = '0;
        opnd_d = '0;
        err_d  = 1'b1;
      end
`endif
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
`ifdef MULDIV_DIV_EN
      if (op_q) begin
        {hi_d, lo_d} = div_step(hi_q, lo_q, opnd_q);
      end else begin
        {hi_d, lo_d} = mul_step(hi_q, lo_q, opnd_q);
      end
`else
      {hi_d, lo_d} = mul_step(hi_q, lo_q, opnd_q);
`endif
    end
  end

  // Outputs: handshakes decoded from state, result taken straight from the datapath.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = {hi_q, lo_q};
    err       = err_q;
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed testbench for iter_muldiv at WIDTH=8. Divide expectations follow
// the MULDIV_DIV_EN build option.
module tb_iter_muldiv;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           err;

  int n_tests = 0;
  int n_fail  = 0;

  iter_muldiv #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // Present one request for a single cycle, then scramble the inputs so a
  // design that does not capture them at acceptance would produce garbage.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = ~o;
    a        = 8'hA5;
    b        = 8'h3C;
  endtask

  // Count cycles after acceptance until out_valid is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    bit found;
    found = 1'b0;
    lat   = -1;
    for (int c = 1; c <= 40; c++) begin
      if (!found) begin
        @(negedge clk);
        if (out_valid) begin
          lat   = c;
          found = 1'b1;
        end
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [W-1:0]   ta [3];
    logic [W-1:0]   tb_ [3];
    logic [2*W-1:0] te [3];
    int lat;
    ta[0] = 8'd13;  tb_[0] = 8'd11;  te[0] = 16'h008F;
    ta[1] = 8'hFF;  tb_[1] = 8'hFF;  te[1] = 16'hFE01;
    ta[2] = 8'h00;  tb_[2] = 8'hFF;  te[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, ta[i], tb_[i]);
      wait_done(lat);
      n_tests++;
      if (lat !== 9) begin n_fail++; $display("FAIL mul%0d_latency: got %0d want 9", i, lat); end
      n_tests++;
      if (result !== te[i]) begin n_fail++; $display("FAIL mul%0d_result: got %h want %h", i, result, te[i]); end
      n_tests++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL mul%0d_err: got %b want 0", i, err); end
      consume();
    end
  endtask

  task automatic test_div();
    logic [W-1:0]   ta [2];
    logic [W-1:0]   tb_ [2];
    logic [2*W-1:0] te [2];
    int lat;
    int elat;
    logic eerr;
    ta[0] = 8'd200; tb_[0] = 8'd7;
    ta[1] = 8'd5;   tb_[1] = 8'd9;
`ifdef MULDIV_DIV_EN
    te[0] = 16'h041C; te[1] = 16'h0500; elat = 9; eerr = 1'b0;
`else
    te[0] = 16'h0000; te[1] = 16'h0000; elat = 1; eerr = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, ta[i], tb_[i]);
      wait_done(lat);
      n_tests++;
      if (lat !== elat) begin n_fail++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, elat); end
      n_tests++;
      if (result !== te[i]) begin n_fail++; $display("FAIL div%0d_result: got %h want %h", i, result, te[i]); end
      n_tests++;
      if (err !== eerr) begin n_fail++; $display("FAIL div%0d_err: got %b want %b", i, err, eerr); end
      consume();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [2*W-1:0] exp_res;
`ifdef MULDIV_DIV_EN
    exp_res = 16'h55FF;
`else
    exp_res = 16'h0000;
`endif
    issue(1'b1, 8'h55, 8'h00);
    wait_done(lat);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL div0_latency: got %0d want 1", lat); end
    n_tests++;
    if (result !== exp_res) begin n_fail++; $display("FAIL div0_result: got %h want %h", result, exp_res); end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL div0_err: got %b want 1", err); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    bit spurious;
    issue(1'b0, 8'd3, 8'd5);
    wait_done(lat);
    n_tests++;
    if (lat !== 9) begin n_fail++; $display("FAIL bp_latency: got %0d want 9", lat); end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      op       = 1'b0;
      a        = 8'd1;
      b        = 8'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d_out_valid: got %b want 1", k, out_valid); end
      n_tests++;
      if (result !== 16'h000F) begin n_fail++; $display("FAIL bp%0d_result: got %h want 000f", k, result); end
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d_in_ready: got %b want 0", k, in_ready); end
    end
    consume();
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_valid: got %b want 0", out_valid); end
    spurious = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    n_tests++;
    if (spurious !== 1'b0) begin n_fail++; $display("FAIL bp_no_queued_op: got out_valid=1 want none"); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(1'b0, 8'h12, 8'h34);
    wait_done(lat);
    n_tests++;
    if (result !== 16'h03A8) begin n_fail++; $display("FAIL b2b0_result: got %h want 03a8", result); end
    consume();
    issue(1'b0, 8'h80, 8'h02);
    wait_done(lat);
    n_tests++;
    if (lat !== 9) begin n_fail++; $display("FAIL b2b1_latency: got %0d want 9", lat); end
    n_tests++;
    if (result !== 16'h0100) begin n_fail++; $display("FAIL b2b1_result: got %h want 0100", result); end
    consume();
  endtask

  task automatic test_reset_midop();
    int lat;
    bit spurious;
    issue(1'b0, 8'hAA, 8'h55);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (result !== 16'h0000) begin n_fail++; $display("FAIL midrst_result: got %h want 0000", result); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    n_tests++;
    if (spurious !== 1'b0) begin n_fail++; $display("FAIL midrst_no_out_valid: got out_valid=1 want none"); end
    issue(1'b0, 8'd3, 8'd4);
    wait_done(lat);
    n_tests++;
    if (lat !== 9) begin n_fail++; $display("FAIL midrst_new_latency: got %0d want 9", lat); end
    n_tests++;
    if (result !== 16'h000C) begin n_fail++; $display("FAIL midrst_new_result: got %h want 000c", result); end
    consume();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
